// File: rtl/serial_uart_tx_if.sv
// Write-side handshake between the processor serial port and the UART transmitter.
interface serial_uart_tx_if;
   logic [7:0] wr_data;
   logic       wr_en;
   logic       ready;

   modport master (output wr_data, output wr_en, input ready);
   modport slave  (input wr_data, input wr_en, output ready);
endinterface

// File: rtl/serial_uart_tx.sv
// Byte FIFO feeding an 8N1 UART serialiser; back-pressures the processor via ready.
// Frames are contiguous when the FIFO stays non-empty across a stop bit.
module serial_uart_tx #(
   parameter int unsigned CLKS_PER_BIT = 434,
   parameter int unsigned FIFO_AW      = 4
) (
   input  logic               clock,
   input  logic               reset,
   serial_uart_tx_if.slave    wr,
   output logic               txd,
   output logic               busy,
   output logic [FIFO_AW:0]   fifo_count,
   output logic               overflow
);

   localparam int unsigned DEPTH  = 2 ** FIFO_AW;
   localparam int unsigned CNT_W  = FIFO_AW + 1;
   localparam int unsigned BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(DEPTH);

   typedef enum logic [1:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [BAUD_W-1:0]   r_baud;
   logic [BAUD_W-1:0]   w_baud_nxt;
   logic [2:0]          r_bit;
   logic [2:0]          w_bit_nxt;
   logic [7:0]          r_shift;
   logic [7:0]          w_shift_nxt;
   logic                r_txd;
   logic                w_txd_nxt;
   logic                r_busy;
   logic                r_overflow;

   logic [7:0]          r_mem [DEPTH];
   logic [FIFO_AW-1:0]  r_rd_ptr;
   logic [FIFO_AW-1:0]  r_wr_ptr;
   logic [CNT_W-1:0]    r_count;
   logic [CNT_W-1:0]    w_count_nxt;

   logic                w_push;
   logic                w_pop;
   logic                w_fifo_nempty;
   logic                w_baud_end;
   logic [7:0]          w_head;

   assign wr.ready      = (r_count != CNT_FULL);
   assign w_push        = wr.wr_en && wr.ready;
   assign w_fifo_nempty = (r_count != '0);
   assign w_baud_end    = (r_baud == BAUD_LAST);
   assign w_head        = r_mem[r_rd_ptr];

   assign txd        = r_txd;
   assign busy       = r_busy;
   assign fifo_count = r_count;
   assign overflow   = r_overflow;

   // Frame sequencing: a pop always lands on the edge that enters START.
   always_comb begin
      w_state_nxt = r_state;
      w_baud_nxt  = w_baud_end ? '0 : r_baud + BAUD_W'(1);
      w_bit_nxt   = r_bit;
      w_shift_nxt = r_shift;
      w_pop       = 1'b0;

      unique case (r_state)
         S_IDLE: begin
            w_baud_nxt = '0;
            if (w_fifo_nempty) begin
               w_pop       = 1'b1;
               w_shift_nxt = w_head;
               w_bit_nxt   = '0;
               w_state_nxt = S_START;
            end
         end
         S_START: begin
            if (w_baud_end) begin
               w_state_nxt = S_DATA;
            end
         end
         S_DATA: begin
            if (w_baud_end) begin
               if (r_bit == 3'd7) begin
                  w_state_nxt = S_STOP;
               end else begin
                  w_shift_nxt = {1'b0, r_shift[7:1]};
                  w_bit_nxt   = r_bit + 3'd1;
               end
            end
         end
         S_STOP: begin
            if (w_baud_end) begin
               if (w_fifo_nempty) begin
                  w_pop       = 1'b1;
                  w_shift_nxt = w_head;
                  w_bit_nxt   = '0;
                  w_state_nxt = S_START;
               end else begin
                  w_state_nxt = S_IDLE;
               end
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // Line level follows the state being entered so txd is a clean register output.
   always_comb begin
      w_txd_nxt = 1'b1;
      unique case (w_state_nxt)
         S_START: w_txd_nxt = 1'b0;
         S_DATA:  w_txd_nxt = w_shift_nxt[0];
         default: w_txd_nxt = 1'b1;
      endcase
   end

   always_comb begin
      w_count_nxt = r_count;
      unique case ({w_push, w_pop})
         2'b10:   w_count_nxt = r_count + CNT_W'(1);
         2'b01:   w_count_nxt = r_count - CNT_W'(1);
         default: w_count_nxt = r_count;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state    <= S_IDLE;
         r_baud     <= '0;
         r_bit      <= '0;
         r_shift    <= '0;
         r_txd      <= 1'b1;
         r_busy     <= 1'b0;
         r_overflow <= 1'b0;
         r_rd_ptr   <= '0;
         r_wr_ptr   <= '0;
         r_count    <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_baud     <= w_baud_nxt;
         r_bit      <= w_bit_nxt;
         r_shift    <= w_shift_nxt;
         r_txd      <= w_txd_nxt;
         r_busy     <= (w_state_nxt != S_IDLE) || (w_count_nxt != '0);
         r_overflow <= r_overflow || (wr.wr_en && !wr.ready);
         r_count    <= w_count_nxt;
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + FIFO_AW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + FIFO_AW'(1);
         end
      end
   end

   // Storage needs no reset; pointers and count define validity.
   always_ff @(posedge clock) begin
      if (!reset && w_push) begin
         r_mem[r_wr_ptr] <= wr.wr_data;
      end
   end

endmodule
